// File: rtl/csr_neighbor_fetcher.sv
// CSR neighbour fetcher: reads ptr[v]/ptr[v+1], then streams data[lo..hi-1] two per cycle into a credit-guarded FIFO.
// Optional statistics counters are built only when the FETCH_STATS_EN macro is defined.
module csr_neighbor_fetcher #(
    parameter int unsigned PROC_BITS    = 4,
    parameter int unsigned PROC_ID      = 0,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [31:0]             vertex_in,
    input  logic                    vertex_valid_in,
    output logic                    ready_out,
    output logic [32+PROC_BITS-1:0] idx_addr,
    output logic                    idx_validin,
    input  logic [31:0]             rowidx_in,
    output logic [32+PROC_BITS-1:0] data_addra,
    output logic [32+PROC_BITS-1:0] data_addrb,
    output logic                    data_validina,
    output logic                    data_validinb,
    input  logic [31:0]             data_ina,
    input  logic [31:0]             data_inb,
    output logic [31:0]             neighbor_out,
    output logic                    neighbor_valid_out,
    output logic                    neighbor_last_out,
    input  logic                    neighbor_ready_in,
    output logic                    done_out,
    output logic [31:0]             degree_out,
    output logic                    err_out,
    output logic [31:0]             stat_neighbors_out,
    output logic [31:0]             stat_stall_out
);
    localparam int unsigned RL = READ_LATENCY;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam logic [PROC_BITS-1:0] TAG = PROC_BITS'(PROC_ID);

    typedef enum logic [2:0] {
        S_IDLE, S_PTR_LO, S_PTR_HI, S_PTR_WAIT, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   vtx_q, vtx_d, lo_q, lo_d, cur_q, cur_d, end_q, end_d;
    logic [31:0]   degree_q, degree_d;
    logic          err_q, err_d;

    // Return trackers: bit RL-1 marks the cycle whose edge samples the read data.
    logic [RL-1:0] iv_q, ih_q, va_q, la_q, vb_q, lb_q;

    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic          fifo_last_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q, wr_b;
    logic [OW-1:0] occ_q, occ_d;

    logic [31:0]   rem, infl, free, idx_a;
    logic          idx_v, idx_hi, idx_ret, idx_ret_hi;
    logic          iss_a, iss_b, last_a, last_b, push_a, push_b, pop;

    function automatic logic [RL-1:0] shift_in(input logic [RL-1:0] sr, input logic b);
        logic [RL-1:0] r;
        r    = sr << 1;
        r[0] = b;
        return r;
    endfunction

    always_comb begin
        infl = '0;
        for (int k = 0; k < RL; k++) begin
            infl = infl + 32'(va_q[k]) + 32'(vb_q[k]);
        end
    end

    assign free       = 32'(FIFO_DEPTH) - 32'(occ_q) - infl;
    assign rem        = end_q - cur_q;
    assign idx_ret    = iv_q[RL-1];
    assign idx_ret_hi = ih_q[RL-1];

    always_comb begin
        state_d  = state_q;
        vtx_d    = vtx_q;
        lo_d     = lo_q;
        cur_d    = cur_q;
        end_d    = end_q;
        degree_d = degree_q;
        err_d    = err_q;
        idx_v    = 1'b0;
        idx_hi   = 1'b0;
        idx_a    = '0;
        iss_a    = 1'b0;
        iss_b    = 1'b0;
        last_a   = 1'b0;
        last_b   = 1'b0;
        // With a one-cycle latency the low pointer returns while still in PTR_HI.
        if (idx_ret && !idx_ret_hi) begin
            lo_d = rowidx_in;
        end
        case (state_q)
            S_IDLE: begin
                if (vertex_valid_in) begin
                    vtx_d   = vertex_in;
                    state_d = S_PTR_LO;
                end
            end
            S_PTR_LO: begin
                idx_v   = 1'b1;
                idx_a   = vtx_q;
                state_d = S_PTR_HI;
            end
            S_PTR_HI: begin
                idx_v   = 1'b1;
                idx_hi  = 1'b1;
                idx_a   = vtx_q + 32'd1;
                state_d = S_PTR_WAIT;
            end
            S_PTR_WAIT: begin
                if (idx_ret && idx_ret_hi) begin
                    if (rowidx_in > lo_q) begin
                        cur_d   = lo_q;
                        end_d   = rowidx_in;
                        state_d = S_STREAM;
                    end else begin
                        err_d    = err_q | (rowidx_in < lo_q);
                        degree_d = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_STREAM: begin
                if (rem >= 32'd2 && free >= 32'd2) begin
                    iss_a  = 1'b1;
                    iss_b  = 1'b1;
                    last_b = (rem == 32'd2);
                    cur_d  = cur_q + 32'd2;
                end else if (rem == 32'd1 && free >= 32'd1) begin
                    iss_a  = 1'b1;
                    last_a = 1'b1;
                    cur_d  = cur_q + 32'd1;
                end
                if (iss_a && cur_d == end_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (infl == '0) begin
                    degree_d = end_q - lo_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign push_a = va_q[RL-1];
    assign push_b = vb_q[RL-1];
    assign pop    = neighbor_valid_out & neighbor_ready_in;
    assign wr_b   = push_a ? wr_q + PW'(1) : wr_q;
    assign occ_d  = occ_q + OW'(push_a) + OW'(push_b) - OW'(pop);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            vtx_q    <= '0;
            lo_q     <= '0;
            cur_q    <= '0;
            end_q    <= '0;
            degree_q <= '0;
            err_q    <= 1'b0;
            iv_q     <= '0;
            ih_q     <= '0;
            va_q     <= '0;
            la_q     <= '0;
            vb_q     <= '0;
            lb_q     <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            vtx_q    <= vtx_d;
            lo_q     <= lo_d;
            cur_q    <= cur_d;
            end_q    <= end_d;
            degree_q <= degree_d;
            err_q    <= err_d;
            iv_q     <= shift_in(iv_q, idx_v);
            ih_q     <= shift_in(ih_q, idx_hi);
            va_q     <= shift_in(va_q, iss_a);
            la_q     <= shift_in(la_q, last_a);
            vb_q     <= shift_in(vb_q, iss_b);
            lb_q     <= shift_in(lb_q, last_b);
            wr_q     <= wr_q + PW'(push_a) + PW'(push_b);
            rd_q     <= rd_q + PW'(pop);
            occ_q    <= occ_d;
        end
    end

    // Port A lands ahead of port B so the FIFO keeps ascending address order.
    always_ff @(posedge clk_in) begin
        if (push_a) begin
            fifo_data_q[wr_q] <= data_ina;
            fifo_last_q[wr_q] <= la_q[RL-1];
        end
        if (push_b) begin
            fifo_data_q[wr_b] <= data_inb;
            fifo_last_q[wr_b] <= lb_q[RL-1];
        end
    end

    assign ready_out          = (state_q == S_IDLE);
    assign idx_validin        = idx_v;
    assign idx_addr           = idx_v ? {TAG, idx_a} : '0;
    assign data_validina      = iss_a;
    assign data_validinb      = iss_b;
    assign data_addra         = iss_a ? {TAG, cur_q} : '0;
    assign data_addrb         = iss_b ? {TAG, cur_q + 32'd1} : '0;
    assign neighbor_valid_out = (occ_q != '0);
    assign neighbor_out       = neighbor_valid_out ? fifo_data_q[rd_q] : '0;
    assign neighbor_last_out  = neighbor_valid_out & fifo_last_q[rd_q];
    assign done_out           = (state_q == S_DONE);
    assign degree_out         = degree_q;
    assign err_out            = err_q;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_nb_q, stat_st_q;
    logic        stall;

    assign stall = (state_q == S_STREAM) && !iss_a;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_nb_q <= '0;
            stat_st_q <= '0;
        end else begin
            if (pop && stat_nb_q != '1) begin
                stat_nb_q <= stat_nb_q + 32'd1;
            end
            if (stall && stat_st_q != '1) begin
                stat_st_q <= stat_st_q + 32'd1;
            end
        end
    end

    assign stat_neighbors_out = stat_nb_q;
    assign stat_stall_out     = stat_st_q;
`else
    assign stat_neighbors_out = '0;
    assign stat_stall_out     = '0;
`endif

endmodule

// File: tb/tb_csr_neighbor_fetcher.sv
// Directed bench for csr_neighbor_fetcher with a fixed-latency three-port memory model.
module tb_csr_neighbor_fetcher;
    localparam int PB  = 4;
    localparam int PID = 5;
    localparam int RL  = 2;
    localparam int AW  = 32 + PB;
    localparam logic [PB-1:0] TAGV = PB'(PID);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [31:0]   vertex_in;
    logic          vertex_valid_in;
    logic          ready_out;
    logic [AW-1:0] idx_addr;
    logic          idx_validin;
    logic [31:0]   rowidx_in;
    logic [AW-1:0] data_addra, data_addrb;
    logic          data_validina, data_validinb;
    logic [31:0]   data_ina, data_inb;
    logic [31:0]   neighbor_out;
    logic          neighbor_valid_out, neighbor_last_out, neighbor_ready_in;
    logic          done_out;
    logic [31:0]   degree_out;
    logic          err_out;
    logic [31:0]   stat_neighbors_out, stat_stall_out;

    csr_neighbor_fetcher #(
        .PROC_BITS(PB), .PROC_ID(PID), .READ_LATENCY(RL), .FIFO_DEPTH(8)
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .vertex_in(vertex_in), .vertex_valid_in(vertex_valid_in), .ready_out(ready_out),
        .idx_addr(idx_addr), .idx_validin(idx_validin), .rowidx_in(rowidx_in),
        .data_addra(data_addra), .data_addrb(data_addrb),
        .data_validina(data_validina), .data_validinb(data_validinb),
        .data_ina(data_ina), .data_inb(data_inb),
        .neighbor_out(neighbor_out), .neighbor_valid_out(neighbor_valid_out),
        .neighbor_last_out(neighbor_last_out), .neighbor_ready_in(neighbor_ready_in),
        .done_out(done_out), .degree_out(degree_out), .err_out(err_out),
        .stat_neighbors_out(stat_neighbors_out), .stat_stall_out(stat_stall_out)
    );

    // Memory model: address sampled at an edge, data sampled by the DUT RL edges later.
    logic [31:0] idx_mem [64];
    logic [31:0] dat_mem [64];
    logic [5:0]  ia_p [RL], aa_p [RL], ba_p [RL];
    logic        iv_p [RL], av_p [RL], bv_p [RL];

    always @(posedge clk) begin
        for (int k = RL - 1; k > 0; k--) begin
            ia_p[k] <= ia_p[k-1]; iv_p[k] <= iv_p[k-1];
            aa_p[k] <= aa_p[k-1]; av_p[k] <= av_p[k-1];
            ba_p[k] <= ba_p[k-1]; bv_p[k] <= bv_p[k-1];
        end
        ia_p[0] <= idx_addr[5:0];   iv_p[0] <= idx_validin;
        aa_p[0] <= data_addra[5:0]; av_p[0] <= data_validina;
        ba_p[0] <= data_addrb[5:0]; bv_p[0] <= data_validinb;
    end

    assign rowidx_in = iv_p[RL-1] ? idx_mem[ia_p[RL-1]] : 32'hDEADBEEF;
    assign data_ina  = av_p[RL-1] ? dat_mem[aa_p[RL-1]] : 32'hDEADBEEF;
    assign data_inb  = bv_p[RL-1] ? dat_mem[ba_p[RL-1]] : 32'hDEADBEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int n_rd = 0, n_pair = 0, n_single = 0, n_done = 0, n_vcyc = 0, bad_tag = 0;
    int first_v = -1, acc = 0;
    logic [31:0] got_v[$], got_l[$], issa[$], issb[$];

    always @(negedge clk) begin
        if (neighbor_valid_out) begin
            n_vcyc++;
            if (first_v < 0) first_v = cyc;
            if (neighbor_ready_in) begin
                got_v.push_back(neighbor_out);
                got_l.push_back({31'd0, neighbor_last_out});
            end
        end
        if (data_validina) begin n_rd++; issa.push_back(data_addra[31:0]); end
        if (data_validinb) begin n_rd++; issb.push_back(data_addrb[31:0]); end
        if (data_validina && data_validinb) n_pair++;
        else if (data_validina) n_single++;
        if (done_out) n_done++;
        if ((idx_validin && idx_addr[AW-1:32] != TAGV) ||
            (data_validina && data_addra[AW-1:32] != TAGV) ||
            (data_validinb && data_addrb[AW-1:32] != TAGV)) bad_tag++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] qv(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFFFFFF;
    endfunction

    task automatic request(input logic [31:0] v);
        @(posedge clk); #1;
        vertex_in = v;
        vertex_valid_in = 1'b1;
        @(posedge clk); #1;
        vertex_valid_in = 1'b0;
        acc = cyc;
        first_v = -1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_out !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, done_out}, 32'd1);
    endtask

    task automatic clear_log();
        got_v.delete(); got_l.delete(); issa.delete(); issb.delete();
    endtask

    task automatic check_stream(input string tag, input int base, input int n);
        int good = 0;
        logic [31:0] lm = '0;
        chk({tag, "_count"}, got_v.size(), n);
        for (int i = 0; i < got_v.size(); i++) begin
            if (got_v[i] == 32'(base + i)) good++;
            if (i < 32) lm[i] = got_l[i][0];
        end
        chk({tag, "_values"}, good, n);
        chk({tag, "_last"}, lm, 32'd1 << (n - 1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int r0, d0, p0, s0, v0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            idx_mem[i] = 32'd0;
            dat_mem[i] = 32'hBAD00000 + 32'(i);
        end
        idx_mem[3] = 5;  idx_mem[4] = 9;
        for (int i = 0; i < 4; i++) dat_mem[5+i] = 32'(10 + i);
        idx_mem[7] = 20; idx_mem[8] = 20;
        idx_mem[10] = 30; idx_mem[11] = 50;
        for (int i = 0; i < 20; i++) dat_mem[30+i] = 32'(100 + i);
        idx_mem[0] = 0; idx_mem[1] = 3;
        for (int i = 0; i < 3; i++) dat_mem[i] = 32'(200 + i);

        rst = 1'b1; vertex_in = '0; vertex_valid_in = 1'b0; neighbor_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        chk("rst_valid", {31'd0, neighbor_valid_out}, 32'd0);
        chk("rst_strobes", {29'd0, idx_validin, data_validina, data_validinb}, 32'd0);
        chk("rst_done_err", {30'd0, done_out, err_out}, 32'd0);
        chk("rst_degree", degree_out, 32'd0);
        chk("rst_stats", stat_neighbors_out | stat_stall_out, 32'd0);

        // Degree 4 at rows 5..8; valid is visible in the cycle ending at edge acc+8.
        clear_log(); r0 = n_rd; d0 = n_done; p0 = n_pair; s0 = n_single;
        request(3);
        wait_done("t1_done", 40);
        repeat (8) @(negedge clk);
        chk("t1_latency", 32'(first_v - acc), 32'd7);
        check_stream("t1", 10, 4);
        chk("t1_degree", degree_out, 32'd4);
        chk("t1_reads", 32'(n_rd - r0), 32'd4);
        chk("t1_pairs", 32'(n_pair - p0), 32'd2);
        chk("t1_singles", 32'(n_single - s0), 32'd0);
        chk("t1_max_b", qv(issb, 1), 32'd8);
        chk("t1_done_pulse", 32'(n_done - d0), 32'd1);
        chk("t1_err", {31'd0, err_out}, 32'd0);

        // Empty row.
        clear_log(); r0 = n_rd; d0 = n_done; v0 = n_vcyc;
        request(7);
        wait_done("t2_done", 40);
        repeat (6) @(negedge clk);
        chk("t2_valid_cycles", 32'(n_vcyc - v0), 32'd0);
        chk("t2_reads", 32'(n_rd - r0), 32'd0);
        chk("t2_degree", degree_out, 32'd0);
        chk("t2_err", {31'd0, err_out}, 32'd0);
        chk("t2_done_pulse", 32'(n_done - d0), 32'd1);

        // Inverted pointers.
        idx_mem[2] = 6; idx_mem[3] = 1;
        clear_log(); r0 = n_rd; v0 = n_vcyc;
        request(2);
        wait_done("t3_done", 40);
        repeat (6) @(negedge clk);
        chk("t3_err", {31'd0, err_out}, 32'd1);
        chk("t3_degree", degree_out, 32'd0);
        chk("t3_reads", 32'(n_rd - r0), 32'd0);
        chk("t3_valid_cycles", 32'(n_vcyc - v0), 32'd0);
        idx_mem[3] = 5;

        // Degree 20 under backpressure: only 8 reads fit before credit runs out.
        clear_log(); r0 = n_rd;
        @(posedge clk); #1 neighbor_ready_in = 1'b0;
        request(10);
        repeat (30) @(negedge clk);
        chk("t4_reads_stalled", 32'(n_rd - r0), 32'd8);
        chk("t4_fifo_valid", {31'd0, neighbor_valid_out}, 32'd1);
        chk("t4_no_pops", got_v.size(), 32'd0);
        @(posedge clk); #1 neighbor_ready_in = 1'b1;
        wait_done("t4_done", 200);
        repeat (12) @(negedge clk);
        check_stream("t4", 100, 20);
        chk("t4_degree", degree_out, 32'd20);
        chk("t4_err_sticky", {31'd0, err_out}, 32'd1);
`ifdef FETCH_STATS_EN
        chk("t4_stat_neighbors", stat_neighbors_out, 32'd24);
        chk("t4_stat_stall_nz", {31'd0, stat_stall_out != 32'd0}, 32'd1);
`else
        chk("t4_stat_neighbors", stat_neighbors_out, 32'd0);
        chk("t4_stat_stall", stat_stall_out, 32'd0);
`endif

        // Odd degree: one pair then a single.
        clear_log(); p0 = n_pair; s0 = n_single;
        request(0);
        wait_done("t5_done", 40);
        repeat (8) @(negedge clk);
        check_stream("t5", 200, 3);
        chk("t5_pairs", 32'(n_pair - p0), 32'd1);
        chk("t5_singles", 32'(n_single - s0), 32'd1);
        chk("t5_a0", qv(issa, 0), 32'd0);
        chk("t5_b0", qv(issb, 0), 32'd1);
        chk("t5_a1", qv(issa, 1), 32'd2);
        chk("t5_degree", degree_out, 32'd3);

        // Reset while reads are in flight; stale returns must be dropped.
        clear_log(); r0 = n_rd;
        request(10);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_inflight", 32'(n_rd - r0), 32'd4);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_valid_after_rst", {31'd0, neighbor_valid_out}, 32'd0);
        chk("t6_ready_after_rst", {31'd0, ready_out}, 32'd1);
        chk("t6_err_cleared", {31'd0, err_out}, 32'd0);
        chk("t6_degree_cleared", degree_out, 32'd0);
        v0 = n_vcyc;
        repeat (6) @(negedge clk);
        chk("t6_no_stale", 32'(n_vcyc - v0), 32'd0);
        chk("t6_stats_cleared", stat_neighbors_out | stat_stall_out, 32'd0);
        clear_log();
        request(3);
        wait_done("t6_done", 40);
        repeat (8) @(negedge clk);
        check_stream("t6", 10, 4);
        chk("t6_degree", degree_out, 32'd4);

        chk("addr_tag", 32'(bad_tag), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/csr_neighbor_fetcher.md
Name: csr_neighbor_fetcher

Overview:
Read initiator for graph_memory, the compressed-sparse-row store. It accepts a vertex id, reads row pointers ptr[v] and ptr[v+1] from the pointer port, then streams neighbour entries data[ptr[v]..ptr[v+1]-1] using both data ports, two reads per cycle. Results go through an internal output FIFO with ready/valid backpressure. One instance serves each graph processing element; PROC_ID tags the upper address bits.

Parameters:
PROC_BITS, 4, width of the processor tag carried in address bits [31+PROC_BITS:32]
PROC_ID, 0, tag value driven on every address
READ_LATENCY, 2, cycles from an address being driven with valid to its data being sampled (fixed, same for all three ports)
FIFO_DEPTH, 8, output FIFO entries (power of 2, at least 4)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
vertex_in  in  32  vertex id to expand
vertex_valid_in  in  1  request strobe; accepted when ready_out=1
ready_out  out  1  high only in IDLE
idx_addr  out  32+PROC_BITS  pointer-port address {PROC_ID, index}
idx_validin  out  1  pointer read strobe
rowidx_in  in  32  pointer-port read data
data_addra / data_addrb  out  32+PROC_BITS  data-port A/B addresses
data_validina / data_validinb  out  1  data-port A/B read strobes
data_ina / data_inb  in  32  data-port A/B read data
neighbor_out  out  32  neighbour vertex id (FIFO head)
neighbor_valid_out  out  1  FIFO non-empty
neighbor_last_out  out  1  head entry is the final neighbour of the current vertex
neighbor_ready_in  in  1  consumer pops when valid&ready
done_out  out  1  one-cycle pulse when the expansion is complete
degree_out  out  32  ptr[v+1]-ptr[v], held from done_out until the next done_out
err_out  out  1  sticky: a fetch had ptr[v+1] < ptr[v]; cleared only by reset
stat_neighbors_out / stat_stall_out  out  32  statistics (see Optional Feature)

Behaviour:
- Reset (rst_in=1 at an edge): state IDLE; all strobes, addresses, neighbor_valid_out, neighbor_last_out, done_out, degree_out, err_out and stats go to 0; FIFO emptied; in-flight tracking cleared, so returns from earlier reads are discarded. ready_out=1 from the first cycle after reset.
- Returned data is ignored unless it matches an in-flight tag. The memory's valid outputs are not used; every return is timed with READ_LATENCY-deep shift registers of {valid, port, last}.
- FSM:
  IDLE: accept on vertex_valid_in & ready_out; latch v -> PTR_LO.
  PTR_LO: drive idx_addr=v with idx_validin=1 for 1 cycle -> PTR_HI.
  PTR_HI: drive v+1 for 1 cycle -> PTR_WAIT.
  PTR_WAIT: capture lo and hi when their tags return. If hi>lo, set cur=lo, end=hi -> STREAM. If hi==lo, set degree=0 -> DONE. If hi<lo, set err_out=1, degree=0 -> DONE.
  STREAM: each cycle with enough credit, issue reads. If end-cur>=2: A=cur, B=cur+1, cur+=2. If exactly 1 remains: A only, cur+=1. When cur==end -> DRAIN.
  DRAIN: wait until the in-flight count is 0 -> DONE.
  DONE: done_out=1 for one cycle, degree_out=hi-lo -> IDLE. FIFO contents may still be draining.
- Credit rule: free = FIFO_DEPTH - occupancy - in_flight_entries. Issue a pair only if free>=2 and a single only if free>=1; otherwise stall (no strobes). The FIFO never overflows.
- Ordering: port A data is pushed before port B data in the same cycle, so the FIFO accepts up to 2 pushes per cycle and output order is ascending address. neighbor_last_out is set on the entry read from address end-1.
- Latency, with ready held high and no stall: acceptance edge at cycle 0; idx reads at cycles 1 and 2; lo/hi captured at cycles 3 and 4; first data strobe at cycle 5; first neighbor_valid_out at cycle 8.
- Simultaneous FIFO push and pop is legal; a pop of the last entry with a push in the same cycle keeps valid high.
- vertex_valid_in while ready_out=0 is ignored, with no queuing.
- Address arithmetic is 32-bit, with wrap-around modulo 2^32 accepted without a check. The upper bits always equal PROC_ID.

Optional Feature:
FETCH_STATS_EN. When defined: stat_neighbors_out counts FIFO pops (valid&ready), and stat_stall_out counts STREAM cycles with no issue due to credit. Both are 32-bit, saturate at all ones and clear on reset. When undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
ptr[3]=5, ptr[4]=9, data[5..8]=10,11,12,13, ready=1, request v=3 -> outputs 10,11,12,13 at cycles 8,8+... in order; last only on 13; done_out pulse; degree_out=4; data_validinb low never paired with addr beyond 8.
ptr[7]=ptr[8]=20, request v=7 -> no neighbor_valid_out; done_out pulses; degree_out=0; err_out=0.
ptr[2]=6, ptr[3]=1 -> err_out=1 sticky; degree_out=0; no data reads issued.
Degree 20, neighbor_ready_in=0 for 30 cycles then 1 -> FIFO holds 8 entries, no strobes while credit is 0, all 20 delivered in order; with FETCH_STATS_EN, stat_neighbors_out=20 and stat_stall_out>0.
Odd degree 3 (ptr[0]=0, ptr[1]=3) -> one pair (A=0, B=1) then a single A=2; output order 0,1,2 values.
rst_in asserted in STREAM with 4 reads in flight -> the next cycle has no valid outputs, ready_out=1; a new request for v=3 returns exactly 10..13 with no stale data.
